// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART echo driver: bus addresses, echo modes,
// FSM states, default baud divisors and the case-swap transform.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'b00,
    ADDR_STAT = 2'b01,
    ADDR_DBL  = 2'b10,
    ADDR_DBH  = 2'b11
  } ioaddr_e;

  typedef enum logic [1:0] {
    MODE_ECHO   = 2'b00,
    MODE_SWAP   = 2'b01,
    MODE_RXONLY = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    ST_PROG_LO,
    ST_PROG_HI,
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_GAP
  } state_t;

  localparam logic [15:0] DEF_DIV0 = 16'h0516;
  localparam logic [15:0] DEF_DIV1 = 16'h028B;
  localparam logic [15:0] DEF_DIV2 = 16'h0146;
  localparam logic [15:0] DEF_DIV3 = 16'h00A3;

  // ASCII letters get bit 5 flipped (upper <-> lower); anything else passes through.
  function automatic logic [7:0] swap_case(input logic [7:0] b);
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
      return b ^ 8'h20;
    end
    return b;
  endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// Control side of the SPART processor bus; the bidirectional data bus stays a module port.
interface spart_echo_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_drv_fifo.sv
// Single-clock FIFO with show-ahead head output; pointers carry an extra wrap bit
// so that full and empty are distinguished by the occupancy count.
module spart_drv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr - r_rd;
  assign o_full    = (o_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_wr == r_rd);
  assign o_head    = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/spart_echo_driver.sv
// Bus master for the SPART core: programs the baud divisor, reads received bytes into
// a FIFO (optionally case-swapped) and writes them back out for transmit.
module spart_echo_driver
  import spart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV0       = DEF_DIV0,
  parameter logic [15:0] DIV1       = DEF_DIV1,
  parameter logic [15:0] DIV2       = DEF_DIV2,
  parameter logic [15:0] DIV3       = DEF_DIV3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  br_cfg,
  input  logic [1:0]                  mode,
  spart_echo_driver_if.master         bus,
  inout  wire  [7:0]                  databus,
  output logic [7:0]                  driver_led,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        baud_ok
);

  state_t      r_state;
  state_t      r_after;
  logic        r_iocs;
  logic        r_iorw;
  ioaddr_e     r_ioaddr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_led;
  logic [1:0]  r_cfg_q;
  logic        r_baud_ok;

  logic [15:0] w_div;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_push_data;
  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;

  always_comb begin
    w_div = DIV0;
    case (br_cfg)
      2'b01:   w_div = DIV1;
      2'b10:   w_div = DIV2;
      2'b11:   w_div = DIV3;
      default: w_div = DIV0;
    endcase
  end

  // A read completes on the edge that leaves GAP; mode is evaluated at that edge.
  assign w_push      = (r_state == ST_GAP) && r_iorw && (mode != MODE_RXONLY);
  assign w_push_data = (mode == MODE_SWAP) ? swap_case(databus) : databus;
  assign w_pop       = (r_state == ST_WR);

  spart_drv_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_data),
    .o_head  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Access states launch a one-cycle iocs pulse that is live while the FSM sits in GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_PROG_LO;
      r_after   <= ST_IDLE;
      r_iocs    <= 1'b0;
      r_iorw    <= 1'b1;
      r_ioaddr  <= ADDR_DATA;
      r_wdata   <= 8'h00;
      r_led     <= 8'h00;
      r_cfg_q   <= 2'b00;
      r_baud_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_PROG_LO: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= ADDR_DBL;
          r_wdata  <= w_div[7:0];
          r_after  <= ST_PROG_HI;
          r_state  <= ST_GAP;
        end
        ST_PROG_HI: begin
          r_iocs    <= 1'b1;
          r_iorw    <= 1'b0;
          r_ioaddr  <= ADDR_DBH;
          r_wdata   <= w_div[15:8];
          r_baud_ok <= 1'b1;
          r_cfg_q   <= br_cfg;
          r_after   <= ST_IDLE;
          r_state   <= ST_GAP;
        end
        ST_IDLE: begin
          // Rate changes wait for the FIFO to drain so queued bytes leave at the old rate.
          if (br_cfg != r_cfg_q && w_empty) begin
            r_baud_ok <= 1'b0;
            r_state   <= ST_PROG_LO;
          end else if (bus.rda && !w_full) begin
            r_state <= ST_RD;
          end else if (bus.tbr && !w_empty && mode != MODE_RXONLY) begin
            r_state <= ST_WR;
          end
        end
        ST_RD: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b1;
          r_ioaddr <= ADDR_DATA;
          r_after  <= ST_IDLE;
          r_state  <= ST_GAP;
        end
        ST_WR: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= ADDR_DATA;
          r_wdata  <= w_head;
          r_after  <= ST_IDLE;
          r_state  <= ST_GAP;
        end
        ST_GAP: begin
          if (r_iorw) r_led <= databus;
          r_iocs  <= 1'b0;
          r_iorw  <= 1'b1;
          r_state <= r_after;
        end
        default: r_state <= ST_PROG_LO;
      endcase
    end
  end

  assign bus.iocs   = r_iocs;
  assign bus.iorw   = r_iorw;
  assign bus.ioaddr = r_ioaddr;
  assign databus    = (r_iocs && !r_iorw) ? r_wdata : 8'hzz;
  assign driver_led = r_led;
  assign baud_ok    = r_baud_ok;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Directed bench for spart_echo_driver: a small SPART model feeds bytes, logs bus writes,
// and each step checks the write log, counters and status outputs against hand values.
module tb_spart_echo_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic [1:0] mode = 2'b00;
  wire  [7:0] databus;
  logic [7:0] driver_led;
  logic [3:0] fifo_count;
  logic       baud_ok;

  int checks = 0;
  int errors = 0;

  // SPART model state
  logic [7:0] rx_mem [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic [7:0] rd_drive = 8'h00;
  int         wlog [0:63];
  int         n_writes = 0;
  int         n_reads = 0;
  int         gap_viol = 0;
  logic       prev_iocs = 1'b0;
  logic       bok_at_dbl = 1'b1;

  spart_echo_driver_if bus_if ();

  spart_echo_driver #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .mode       (mode),
    .bus        (bus_if),
    .databus    (databus),
    .driver_led (driver_led),
    .fifo_count (fifo_count),
    .baud_ok    (baud_ok)
  );

  initial forever #5 clk = ~clk;

  assign databus    = (bus_if.iocs && bus_if.iorw) ? rd_drive : 8'hzz;
  assign bus_if.rda = (rx_rd < rx_wr);

  // Bus observer: one line per bus transaction.
  always @(negedge clk) begin
    if (bus_if.iocs) begin
      if (prev_iocs) gap_viol++;
      if (bus_if.iorw) begin
        rd_drive = rx_mem[rx_rd & 63];
        rx_rd++;
        n_reads++;
        $display("[%0t] RD  addr=%0d data=%02h", $time, bus_if.ioaddr, rd_drive);
      end else begin
        wlog[n_writes & 63] = {22'd0, bus_if.ioaddr, databus};
        if (bus_if.ioaddr == 2'b10) bok_at_dbl = baud_ok;
        n_writes++;
        $display("[%0t] WR  addr=%0d data=%02h", $time, bus_if.ioaddr, databus);
      end
    end
    prev_iocs = bus_if.iocs;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_wr & 63] = b;
    rx_wr++;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (n_writes < n && c < budget) begin
      tick(1);
      c++;
    end
    chk(tag, n_writes, n);
  endtask

  initial begin
    bus_if.tbr = 1'b0;

    // Reset state
    tick(3);
    chk("rst_iocs", 32'(bus_if.iocs), 32'd0);
    chk("rst_iorw", 32'(bus_if.iorw), 32'd1);
    chk("rst_addr", 32'(bus_if.ioaddr), 32'd0);
    chk("rst_led", 32'(driver_led), 32'h00);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_bok", 32'(baud_ok), 32'd0);

    // Divisor programming for br_cfg=01
    rst = 1'b0;
    wait_writes(2, 50, "prog_wait");
    chk("prog_lo", wlog[0], 32'h28B);
    chk("prog_hi", wlog[1], 32'h302);
    chk("prog_bok", 32'(baud_ok), 32'd1);
    tick(20);
    chk("quiet_wr", n_writes, 32'd2);
    chk("quiet_rd", n_reads, 32'd0);

    // Raw echo of one byte
    bus_if.tbr = 1'b1;
    push_byte(8'h41);
    begin
      int c = 0;
      while (n_reads < 1 && c < 50) begin tick(1); c++; end
    end
    chk("echo_cnt1", 32'(fifo_count), 32'd1);
    wait_writes(3, 50, "echo_wait");
    chk("echo_data", wlog[2], 32'h041);
    chk("echo_led", 32'(driver_led), 32'h41);
    chk("echo_cnt0", 32'(fifo_count), 32'd0);

    // Case-swap echo
    mode = 2'b01;
    push_byte(8'h61);
    push_byte(8'h5A);
    push_byte(8'h31);
    wait_writes(6, 100, "swap_wait");
    chk("swap0", wlog[3], 32'h041);
    chk("swap1", wlog[4], 32'h07A);
    chk("swap2", wlog[5], 32'h031);
    chk("swap_led", 32'(driver_led), 32'h31);

    // Backpressure: 9 bytes into an 8-entry FIFO with transmit blocked
    mode = 2'b00;
    bus_if.tbr = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i));
    tick(60);
    chk("full_rd", n_reads, 32'd12);
    chk("full_cnt", 32'(fifo_count), 32'd8);
    chk("full_rda", 32'(bus_if.rda), 32'd1);
    chk("full_wr", n_writes, 32'd6);
    bus_if.tbr = 1'b1;
    wait_writes(15, 200, "drain_wait");
    for (int i = 0; i < 9; i++) chk($sformatf("drain%0d", i), wlog[6 + i], 32'(8'h10 + i));
    chk("drain_rd", n_reads, 32'd13);
    chk("drain_cnt", 32'(fifo_count), 32'd0);

    // Baud change waits for queued bytes to drain
    bus_if.tbr = 1'b0;
    push_byte(8'h51);
    push_byte(8'h52);
    push_byte(8'h53);
    tick(40);
    chk("q3_cnt", 32'(fifo_count), 32'd3);
    br_cfg = 2'b11;
    tick(10);
    chk("hold_bok", 32'(baud_ok), 32'd1);
    chk("hold_wr", n_writes, 32'd15);
    bus_if.tbr = 1'b1;
    wait_writes(20, 200, "rebaud_wait");
    chk("rb_tx0", wlog[15], 32'h051);
    chk("rb_tx1", wlog[16], 32'h052);
    chk("rb_tx2", wlog[17], 32'h053);
    chk("rb_lo", wlog[18], 32'h2A3);
    chk("rb_hi", wlog[19], 32'h300);
    chk("rb_bok_low", 32'(bok_at_dbl), 32'd0);
    chk("rb_bok", 32'(baud_ok), 32'd1);

    // Receive-only mode
    mode = 2'b10;
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    push_byte(8'h64);
    tick(40);
    chk("rx_wr", n_writes, 32'd20);
    chk("rx_rd", n_reads, 32'd20);
    chk("rx_led", 32'(driver_led), 32'h64);
    chk("rx_cnt", 32'(fifo_count), 32'd0);

    // Reset during a read cycle
    push_byte(8'h77);
    begin
      int c = 0;
      while (!(bus_if.iocs && bus_if.iorw) && c < 50) begin tick(1); c++; end
    end
    chk("rd_seen", 32'(bus_if.iocs && bus_if.iorw), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("mrst_iocs", 32'(bus_if.iocs), 32'd0);
    chk("mrst_led", 32'(driver_led), 32'h00);
    chk("mrst_bok", 32'(baud_ok), 32'd0);
    chk("mrst_cnt", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    wait_writes(22, 50, "reprog_wait");
    chk("reprog_lo", wlog[20], 32'h2A3);
    chk("reprog_hi", wlog[21], 32'h300);
    chk("gap_viol", gap_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
